// File: rtl/immd_gen_pipe.sv
// Two-stage RV immediate generator: decode format, then assemble/sign-extend.
// Define IMMD_GEN_CSR_EN to emit zero-extended zimm for CSRRWI/CSRRSI/CSRRCI.
module immd_gen_pipe #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] generated_immd,
    output logic [2:0]           immd_fmt,
    output logic                 illegal
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    localparam bit RV64 = (WORD_SIZE == 64);

    if (WORD_SIZE != 32 && WORD_SIZE != 64) begin : g_bad_word_size
        $error("immd_gen_pipe: WORD_SIZE must be 32 or 64");
    end

    logic                 w_s2_adv;
    logic                 w_s1_adv;
    logic                 w_s1_ready;
    logic                 w_accept;
    logic [6:0]           w_op;
    logic [2:0]           w_fmt;
    logic                 w_zimm;
    logic [31:0]          w_imm32;
    logic [WORD_SIZE-1:0] w_immd;

    logic                 r_s1_valid;
    logic [31:7]          r_s1_instr;
    logic [2:0]           r_s1_fmt;
    logic                 r_s1_zimm;
    logic                 r_s2_valid;
    logic [WORD_SIZE-1:0] r_s2_immd;
    logic [2:0]           r_s2_fmt;
    logic                 r_s2_ill;

    assign w_s2_adv   = !r_s2_valid || out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_adv;
    assign w_s1_ready = !r_s1_valid || w_s2_adv;
    assign in_ready   = w_s1_ready && !flush;
    assign w_accept   = in_valid && in_ready;
    assign w_op       = instr[6:0];

    // Every listed opcode ends in 2'b11, so compressed encodings fall to illegal.
    always_comb begin
        w_fmt  = FMT_ILL;
        w_zimm = 1'b0;
        unique case (1'b1)
            (w_op == OP_LUI),
            (w_op == OP_AUIPC):          w_fmt = FMT_U;
            (w_op == OP_JAL):            w_fmt = FMT_J;
            (w_op == OP_BRANCH):         w_fmt = FMT_B;
            (w_op == OP_STORE):          w_fmt = FMT_S;
            (w_op == OP_LOAD),
            (w_op == OP_IMM),
            (w_op == OP_JALR),
            (w_op == OP_FENCE):          w_fmt = FMT_I;
            (w_op == OP_SYSTEM): begin
                w_fmt = FMT_I;
`ifdef IMMD_GEN_CSR_EN
                w_zimm = instr[14];
`endif
            end
            (w_op == OP_REG):            w_fmt = FMT_R;
            (RV64 && w_op == OP_IMM32):  w_fmt = FMT_I;
            (RV64 && w_op == OP_REG32):  w_fmt = FMT_R;
            default:                     w_fmt = FMT_ILL;
        endcase
    end

    always_comb begin
        w_imm32 = '0;
        case (r_s1_fmt)
            FMT_I: w_imm32 = r_s1_zimm ? {27'd0, r_s1_instr[19:15]}
                                       : {{20{r_s1_instr[31]}}, r_s1_instr[31:20]};
            FMT_S: w_imm32 = {{20{r_s1_instr[31]}}, r_s1_instr[31:25],
                              r_s1_instr[11:7]};
            FMT_B: w_imm32 = {{19{r_s1_instr[31]}}, r_s1_instr[31], r_s1_instr[7],
                              r_s1_instr[30:25], r_s1_instr[11:8], 1'b0};
            FMT_U: w_imm32 = {r_s1_instr[31:12], 12'd0};
            FMT_J: w_imm32 = {{11{r_s1_instr[31]}}, r_s1_instr[31],
                              r_s1_instr[19:12], r_s1_instr[20],
                              r_s1_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    // Bit 31 of every form is instr[31] (or 0 for zimm), so one extension suffices.
    assign w_immd = WORD_SIZE'($signed(w_imm32));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_instr <= '0;
            r_s1_fmt   <= FMT_R;
            r_s1_zimm  <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_ready) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_instr <= instr[31:7];
                r_s1_fmt   <= w_fmt;
                r_s1_zimm  <= w_zimm;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s2_valid <= 1'b0;
            r_s2_immd  <= '0;
            r_s2_fmt   <= FMT_R;
            r_s2_ill   <= 1'b0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (w_s1_adv) begin
                r_s2_immd <= w_immd;
                r_s2_fmt  <= r_s1_fmt;
                r_s2_ill  <= (r_s1_fmt == FMT_ILL);
            end
        end
    end

    assign out_valid      = r_s2_valid;
    assign generated_immd = r_s2_immd;
    assign immd_fmt       = r_s2_fmt;
    assign illegal        = r_s2_ill;

endmodule

// File: tb/tb_immd_gen_pipe.sv
// Bench for immd_gen_pipe: RV32 and RV64 instances driven in lockstep.
// Directed vector table, pipeline corner sequences, then random vs. a model.
module tb_immd_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        out_ready = 1'b0;

    logic        ir32, ov32, il32;
    logic [31:0] im32;
    logic [2:0]  fm32;
    logic        ir64, ov64, il64;
    logic [63:0] im64;
    logic [2:0]  fm64;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    immd_gen_pipe #(.WORD_SIZE(32)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir32), .instr(instr),
        .out_valid(ov32), .out_ready(out_ready),
        .generated_immd(im32), .immd_fmt(fm32), .illegal(il32)
    );

    immd_gen_pipe #(.WORD_SIZE(64)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir64), .instr(instr),
        .out_valid(ov64), .out_ready(out_ready),
        .generated_immd(im64), .immd_fmt(fm64), .illegal(il64)
    );

`ifdef IMMD_GEN_CSR_EN
    localparam logic [31:0] CSR_IMM = 32'h0000_0005;
`else
    localparam logic [31:0] CSR_IMM = 32'h0000_0300;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
    } vec_t;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } res_t;

    vec_t        vecs[$];
    logic [31:0] q[$];
    logic [6:0]  ops[13] = '{7'h37, 7'h17, 7'h6F, 7'h63, 7'h23, 7'h03, 7'h13,
                             7'h67, 7'h0F, 7'h73, 7'h33, 7'h1B, 7'h3B};

    task automatic chk(input string name, input logic [71:0] act,
                       input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: immediate value as a signed integer built from field weights.
    function automatic res_t model(input logic [31:0] i, input bit rv64);
        res_t   r;
        longint v = 0;
        int     f = 7;
        case (i[6:0])
            7'h37, 7'h17: begin
                f = 4;
                v = longint'(i[31:12]) * 4096;
                if (i[31]) v -= longint'(1) << 32;
            end
            7'h6F: begin
                f = 5;
                v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
                  + longint'(i[30:21]) * 2;
                if (i[31]) v -= longint'(1) << 20;
            end
            7'h63: begin
                f = 3;
                v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
                  + longint'(i[11:8]) * 2;
                if (i[31]) v -= 4096;
            end
            7'h23: begin
                f = 2;
                v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
                if (i[31]) v -= 4096;
            end
            7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: begin
                f = 1;
                v = longint'(i[31:20]);
                if (i[31]) v -= 4096;
`ifdef IMMD_GEN_CSR_EN
                if (i[6:0] == 7'h73 && i[14]) v = longint'(i[19:15]);
`endif
            end
            7'h33: f = 0;
            7'h1B: if (rv64) begin
                f = 1;
                v = longint'(i[31:20]);
                if (i[31]) v -= 4096;
            end
            7'h3B: if (rv64) f = 0;
            default: f = 7;
        endcase
        r.imm = 64'(v);
        r.fmt = 3'(f);
        r.ill = (f == 7);
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(7) == 0) return r;
        return {r[31:7], ops[$urandom_range(12)]};
    endfunction

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        in_valid = 1'b1; instr = v.instr; out_ready = 1'b1;
        #1 chk("vec_in_ready", {ir32, ir64}, 2'b11);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("vec_lat1", {ov32, ov64}, 2'b00);
        @(negedge clk);
        #1 chk("vec_lat2", {ov32, ov64}, 2'b11);
        chk($sformatf("vec32_%h", v.instr), {im32, fm32, il32},
            {v.imm32, v.fmt32, v.ill32});
        chk($sformatf("vec64_%h", v.instr), {im64, fm64, il64},
            {v.imm64, v.fmt64, v.ill64});
    endtask

    logic        pv = 1'b0, pr = 1'b1, pf = 1'b0;
    logic [71:0] prev32, prev64;

    // Checks the current cycle's outputs and books the coming edge's transfers.
    task automatic step_check();
        res_t e;
        chk("rnd_in_ready", {ir32, ir64},
            {2{!flush && (q.size() < 2 || out_ready)}});
        if (pv && !pr && !pf) begin
            chk("rnd_hold32", {ov32, im32, fm32, il32}, prev32);
            chk("rnd_hold64", {ov64, im64, fm64, il64}, prev64);
        end
        if (q.size() == 0) chk("rnd_idle", {ov32, ov64}, 2'b00);
        if (ov32 && out_ready && q.size() > 0) begin
            e = model(q[0], 1'b0);
            chk("rnd32", {ov32, im32, fm32, il32}, {1'b1, e.imm[31:0], e.fmt, e.ill});
            e = model(q[0], 1'b1);
            chk("rnd64", {ov64, im64, fm64, il64}, {1'b1, e});
            void'(q.pop_front());
        end
        if (in_valid && ir32) q.push_back(instr);
        if (flush) q.delete();
        pv = ov32; pr = out_ready; pf = flush;
        prev32 = {ov32, im32, fm32, il32};
        prev64 = {ov64, im64, fm64, il64};
    endtask

    initial begin
        logic [31:0] bp[4];
        int sent, got;

        vecs.push_back('{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0});
        vecs.push_back('{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 1'b0});
        vecs.push_back('{32'h80000037, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF_80000000, 3'd4, 1'b0});
        vecs.push_back('{32'h12345017, 32'h12345000, 3'd4, 1'b0, 64'h00000000_12345000, 3'd4, 1'b0});
        vecs.push_back('{32'hFE000E23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0});
        vecs.push_back('{32'h0080006F, 32'h00000008, 3'd5, 1'b0, 64'h8, 3'd5, 1'b0});
        vecs.push_back('{32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFF_FFFFFFFC, 3'd5, 1'b0});
        vecs.push_back('{32'h002081B3, 32'h0, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0});
        vecs.push_back('{32'h00000000, 32'h0, 3'd7, 1'b1, 64'h0, 3'd7, 1'b1});
        vecs.push_back('{32'hFFF00090, 32'h0, 3'd7, 1'b1, 64'h0, 3'd7, 1'b1});
        vecs.push_back('{32'hFFF0809B, 32'h0, 3'd7, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0});
        vecs.push_back('{32'h002081BB, 32'h0, 3'd7, 1'b1, 64'h0, 3'd0, 1'b0});
        vecs.push_back('{32'h0FF0000F, 32'h000000FF, 3'd1, 1'b0, 64'hFF, 3'd1, 1'b0});
        vecs.push_back('{32'h30529073, 32'h00000305, 3'd1, 1'b0, 64'h305, 3'd1, 1'b0});
        vecs.push_back('{32'h3002D073, CSR_IMM, 3'd1, 1'b0, {32'd0, CSR_IMM}, 3'd1, 1'b0});

        #1;
        chk("rst32", {ov32, im32, fm32, il32}, '0);
        chk("rst64", {ov64, im64, fm64, il64}, '0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rst_in_ready", {ir32, ir64}, 2'b11);

        foreach (vecs[k]) run_vec(vecs[k]);

        for (int k = 0; k < 4; k++) bp[k] = 32'h00000093 | (32'(k + 1) << 20);
        sent = 0; got = 0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            @(negedge clk);
            in_valid  = (sent < 4);
            instr     = (sent < 4) ? bp[sent] : 32'h0;
            out_ready = (c >= 5);
            #1;
            if (c < 5) begin
                chk("bp_in_ready", {ir32, ir64}, {2{c < 2}});
                chk("bp_valid", {ov32, ov64}, {2{c >= 2}});
                if (c >= 2) chk("bp_stable", {im32, im64}, {32'd1, 64'd1});
            end
            if (ov32 && out_ready) begin
                chk("bp_order", {im32, im64}, {32'(got + 1), 64'(got + 1)});
                got++;
            end
            if (in_valid && ir32) sent++;
        end
        chk("bp_count", 72'(got), 72'd4);

        @(negedge clk);
        in_valid = 1'b1; instr = 32'h00100093; out_ready = 1'b0;
        @(negedge clk);
        instr = 32'h00200093;
        @(negedge clk);
        flush = 1'b1; instr = 32'h00300093;
        #1 chk("flush_full", {ov32, ov64}, 2'b11);
        chk("flush_in_ready", {ir32, ir64}, 2'b00);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1 chk("flush_out", {ov32, ov64, ir32, ir64}, 4'b0011);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 chk("flush_quiet", {ov32, ov64}, 2'b00);
        end

        @(negedge clk);
        in_valid = 1'b1; instr = 32'h80000037; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("arst_full", {ov32, ov64}, 2'b11);
        #2 rst = 1'b0;
        #1;
        chk("arst32", {ov32, im32, fm32, il32}, '0);
        chk("arst64", {ov64, im64, fm64, il64}, '0);
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1 chk("arst_quiet", {ov32, ov64}, 2'b00);
        end

        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(3) != 0);
            instr     = rand_instr();
            out_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(23) == 0);
            #1 step_check();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1 step_check();
        end
        chk("drain", 72'(q.size()), 72'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
